joust2_input_cond: RTL

//  Conditions raw hps_io joystick words into the button levels consumed by williams2.
//  Per-input 2-FF sync and debounce, player swap, and a fixed-width coin pulse with lockout gap.

---
 rtl/joust2_input_cond.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/joust2_input_cond.sv
// joust2_input_cond: joystick sync/debounce, player swap and coin pulse shaping for williams2.
// Optional flap autofire is compiled in when INPUT_COND_AUTOFIRE_EN is defined.
module joust2_input_cond #(
    parameter int DEBOUNCE_CYCLES   = 12000,
    parameter int COIN_PULSE_CYCLES = 600000,
    parameter int COIN_GAP_CYCLES   = 600000,
    parameter int AUTOFIRE_HALF     = 360000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] joy1,
    input  logic [15:0] joy2,
    input  logic        swap,
`ifdef INPUT_COND_AUTOFIRE_EN
    input  logic        autofire,
`endif
    output logic        btn_left_1,
    output logic        btn_right_1,
    output logic        btn_flap_1,
    output logic        btn_start_1,
    output logic        btn_left_2,
    output logic        btn_right_2,
    output logic        btn_flap_2,
    output logic        btn_start_2,
    output logic        btn_coin,
    output logic        btn_pause
);

    localparam int NCH = 10;
    localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam int CMAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                          COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   =
        CW'((COIN_GAP_CYCLES > 0) ? COIN_GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    // Channel map: [3:0] player 1, [7:4] player 2 (left,right,flap,start), [8] coin, [9] pause
    logic [NCH-1:0] raw;
    logic [NCH-1:0] s1;
    logic [NCH-1:0] s2;
    logic [NCH-1:0] deb;
    logic           unused_joy;

    assign raw = {joy1[7] | joy2[7], joy1[6] | joy2[6],
                  joy2[5], joy2[4], joy2[0], joy2[1],
                  joy1[5], joy1[4], joy1[0], joy1[1]};

    assign unused_joy = ^{joy1[15:8], joy1[3:2], joy2[15:8], joy2[3:2]};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          level;

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (s2[i] == level) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                level <= s2[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[i] = level;
    end

    logic [3:0] p1_sel;
    logic [3:0] p2_sel;
    logic [1:0] flap_req;
    logic [1:0] flap_nx;

    assign p1_sel   = swap ? deb[7:4] : deb[3:0];
    assign p2_sel   = swap ? deb[3:0] : deb[7:4];
    assign flap_req = {p2_sel[2], p1_sel[2]};

`ifdef INPUT_COND_AUTOFIRE_EN
    localparam int AW = $clog2(AUTOFIRE_HALF + 1);
    localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_HALF - 1);

    for (genvar p = 0; p < 2; p++) begin : g_af
        logic [AW-1:0] af_cnt;
        logic          af_phase;

        // Phase restarts high so a fresh press always fires immediately
        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                af_cnt   <= '0;
                af_phase <= 1'b1;
            end else if (autofire && flap_req[p]) begin
                if (af_cnt == AF_LAST) begin
                    af_cnt   <= '0;
                    af_phase <= ~af_phase;
                end else begin
                    af_cnt <= af_cnt + 1'b1;
                end
            end else begin
                af_cnt   <= '0;
                af_phase <= 1'b1;
            end
        end

        assign flap_nx[p] = autofire ? (flap_req[p] & af_phase) : flap_req[p];
    end
`else
    localparam int af_half_unused = AUTOFIRE_HALF;

    assign flap_nx = flap_req;
`endif

    coin_state_t   state;
    coin_state_t   state_nx;
    logic [CW-1:0] ccnt;
    logic [CW-1:0] ccnt_nx;
    logic          coin_prev;
    logic          coin_rise;
    logic          coin_nx;

    assign coin_rise = deb[8] & ~coin_prev;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ccnt      <= '0;
            coin_prev <= 1'b0;
        end else begin
            state     <= state_nx;
            ccnt      <= ccnt_nx;
            coin_prev <= deb[8];
        end
    end

    // Edges arriving outside IDLE are simply ignored
    always_comb begin
        state_nx = state;
        ccnt_nx  = ccnt;
        unique case (state)
            IDLE: begin
                if (coin_rise) begin
                    state_nx = PULSE;
                    ccnt_nx  = '0;
                end
            end
            PULSE: begin
                if (ccnt == PULSE_LAST) begin
                    ccnt_nx  = '0;
                    state_nx = (COIN_GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    ccnt_nx = ccnt + 1'b1;
                end
            end
            GAP: begin
                if (ccnt == GAP_LAST) begin
                    ccnt_nx  = '0;
                    state_nx = IDLE;
                end else begin
                    ccnt_nx = ccnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                ccnt_nx  = '0;
            end
        endcase
    end

    always_comb begin
        coin_nx = (state_nx == PULSE);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            btn_left_1  <= 1'b0;
            btn_right_1 <= 1'b0;
            btn_flap_1  <= 1'b0;
            btn_start_1 <= 1'b0;
            btn_left_2  <= 1'b0;
            btn_right_2 <= 1'b0;
            btn_flap_2  <= 1'b0;
            btn_start_2 <= 1'b0;
            btn_coin    <= 1'b0;
            btn_pause   <= 1'b0;
        end else begin
            btn_left_1  <= p1_sel[0];
            btn_right_1 <= p1_sel[1];
            btn_flap_1  <= flap_nx[0];
            btn_start_1 <= p1_sel[3];
            btn_left_2  <= p2_sel[0];
            btn_right_2 <= p2_sel[1];
            btn_flap_2  <= flap_nx[1];
            btn_start_2 <= p2_sel[3];
            btn_coin    <= coin_nx;
            btn_pause   <= deb[9];
        end
    end

endmodule
